alu_rsp_serializer: RTL and testbench

- Consumer end of the ALU result interface (comparator, arithmetic, logic and shift units): captures a result word with its valid flag and unit tag.
- Frames each result as a header byte plus data bytes, LSB byte first.
- Drives them over a byte-wide valid/ready stream toward the UART TX path.
- Holds one in-flight frame plus one pending result, and flags drops.

---
 rtl/alu_rsp_pkg.sv | 32 +++
 rtl/alu_rsp_slot.sv | 56 +++++
 rtl/alu_rsp_serializer.sv | 214 +++++++++++++++++++++
 tb/tb_alu_rsp_serializer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rsp_pkg.sv
// Shared definitions for the ALU result serializer: FSM state encoding,
// unit tag codes, header field layout and the byte-count helper.
// Optional feature macro: ALU_RSP_CHECKSUM_EN adds the CHK state.
package alu_rsp_pkg;

  // FSM state encoding; CHK exists only when the checksum trailer is built
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
`ifdef ALU_RSP_CHECKSUM_EN
    , ST_CHK = 2'd3
`endif
  } state_t;

  // Source unit codes carried in the header tag field
  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  // Header layout: tag in the top bits, byte count in the low nibble
  localparam int HDR_TAG_MSB   = 7;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_WIDTH = 4;

  // Number of payload bytes carried per result word
  function automatic int nbytes(input int res_width);
    return res_width / 8;
  endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// Holding register for one result word with its unit tag and a valid flag.
// Used twice by the serializer: once for the in-flight frame, once for the
// pending result. A load in the same cycle as a clear takes precedence.
module alu_rsp_slot
  import alu_rsp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [TAG_WIDTH-1:0]  load_tag,
  output logic [DATA_WIDTH-1:0] data,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  valid_q, valid_d;

  // Next-state: load overrides clear so a hand-over and refill can coincide
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      tag_d   = load_tag;
      valid_d = 1'b1;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Storage flops, emptied by the asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign tag   = tag_q;
  assign valid = valid_q;

endmodule

// File: rtl/alu_rsp_serializer.sv
// Captures ALU results and sends each one as a framed byte stream
// (header, then data bytes LSB first) over a valid/ready byte interface.
// One frame is in flight and one result may wait; further results are
// dropped and flagged on the sticky OVERFLOW output.
// Optional feature macro: ALU_RSP_CHECKSUM_EN appends an XOR checksum byte.
module alu_rsp_serializer
  import alu_rsp_pkg::*;
#(
  parameter int RES_WIDTH = 16,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [RES_WIDTH-1:0] RES_DATA,
  input  logic [TAG_WIDTH-1:0] RES_TAG,
  input  logic                 RES_VALID,
  output logic [7:0]           TX_DATA,
  output logic                 TX_VALID,
  input  logic                 TX_READY,
  input  logic                 OVF_CLR,
  output logic                 BUSY,
  output logic                 OVERFLOW
);

  localparam int         NBYTES   = nbytes(RES_WIDTH);
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       overflow_q, overflow_d;
`ifdef ALU_RSP_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  logic                 xfer;
  logic                 frame_end;
  logic                 act_load, act_clear, act_valid;
  logic [RES_WIDTH-1:0] act_load_data, act_data, act_data_nxt;
  logic [TAG_WIDTH-1:0] act_load_tag, act_tag, act_tag_nxt;
  logic                 pend_load, pend_clear, pend_valid;
  logic [RES_WIDTH-1:0] pend_data;
  logic [TAG_WIDTH-1:0] pend_tag;
  logic [7:0]           header_d;
  logic [7:0]           byte_sel;

  alu_rsp_slot #(.DATA_WIDTH(RES_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_active (
    .CLK       (CLK),
    .RST       (RST),
    .load      (act_load),
    .clear     (act_clear),
    .load_data (act_load_data),
    .load_tag  (act_load_tag),
    .data      (act_data),
    .tag       (act_tag),
    .valid     (act_valid)
  );

  alu_rsp_slot #(.DATA_WIDTH(RES_WIDTH), .TAG_WIDTH(TAG_WIDTH)) u_pending (
    .CLK       (CLK),
    .RST       (RST),
    .load      (pend_load),
    .clear     (pend_clear),
    .load_data (RES_DATA),
    .load_tag  (RES_TAG),
    .data      (pend_data),
    .tag       (pend_tag),
    .valid     (pend_valid)
  );

  // Frame sequencing, slot hand-over and drop detection
  always_comb begin
    xfer          = tx_valid_q & TX_READY;
    frame_end     = 1'b0;
    state_d       = state_q;
    idx_d         = idx_q;
    overflow_d    = overflow_q & ~OVF_CLR;
    act_load      = 1'b0;
    act_clear     = 1'b0;
    act_load_data = RES_DATA;
    act_load_tag  = RES_TAG;
    pend_load     = 1'b0;
    pend_clear    = 1'b0;
`ifdef ALU_RSP_CHECKSUM_EN
    chk_d         = chk_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (RES_VALID) begin
          act_load = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d = ST_DATA;
          idx_d   = '0;
`ifdef ALU_RSP_CHECKSUM_EN
          chk_d   = chk_q ^ tx_data_q;
`endif
        end
      end
      ST_DATA: begin
        if (xfer) begin
`ifdef ALU_RSP_CHECKSUM_EN
          chk_d = chk_q ^ tx_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef ALU_RSP_CHECKSUM_EN
            state_d = ST_CHK;
`else
            frame_end = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef ALU_RSP_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) frame_end = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      if (pend_valid) begin
        act_load      = 1'b1;
        act_load_data = pend_data;
        act_load_tag  = pend_tag;
        pend_clear    = 1'b1;
        state_d       = ST_HDR;
      end else if (RES_VALID) begin
        act_load = 1'b1;
        state_d  = ST_HDR;
      end else begin
        act_clear = 1'b1;
        state_d   = ST_IDLE;
      end
    end

    if (RES_VALID && (state_q != ST_IDLE)) begin
      if (frame_end) begin
        if (pend_valid) pend_load = 1'b1;
      end else if (!pend_valid) begin
        pend_load = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

`ifdef ALU_RSP_CHECKSUM_EN
    if (act_load) chk_d = '0;
`endif
  end

  // Byte that the output register will present after this edge
  always_comb begin
    act_data_nxt = act_load ? act_load_data : act_data;
    act_tag_nxt  = act_load ? act_load_tag  : act_tag;

    header_d = '0;
    header_d[HDR_TAG_MSB -: TAG_WIDTH] = act_tag_nxt;
    header_d[HDR_LEN_LSB +: HDR_LEN_WIDTH] = 4'(NBYTES);

    byte_sel = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (idx_d == 4'(b)) byte_sel = act_data_nxt[8*b +: 8];
    end

    tx_valid_d = (state_d != ST_IDLE);
    case (state_d)
      ST_HDR:  tx_data_d = header_d;
      ST_DATA: tx_data_d = byte_sel;
`ifdef ALU_RSP_CHECKSUM_EN
      ST_CHK:  tx_data_d = chk_d;
`endif
      default: tx_data_d = '0;
    endcase
  end

  // FSM and registered outputs; reset abandons any partial frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
`ifdef ALU_RSP_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
`ifdef ALU_RSP_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign OVERFLOW = overflow_q;
  // The active slot is valid exactly while the FSM is out of IDLE
  assign BUSY     = act_valid | pend_valid;

endmodule

// File: tb/tb_alu_rsp_serializer.sv
// Self-checking bench for alu_rsp_serializer: a table of single-frame
// vectors, hand-written multi-cycle sequences, and randomized traffic
// compared against a queue-based reference of held results.
// Honours ALU_RSP_CHECKSUM_EN when the design is built with it.
module tb_alu_rsp_serializer;

  localparam int RES_WIDTH = 16;
  localparam int TAG_WIDTH = 2;
  localparam int NB        = RES_WIDTH / 8;
`ifdef ALU_RSP_CHECKSUM_EN
  localparam int FRAME_LEN = NB + 2;
`else
  localparam int FRAME_LEN = NB + 1;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic [RES_WIDTH-1:0] res_data;
  logic [TAG_WIDTH-1:0] res_tag;
  logic                 res_valid;
  logic [7:0]           TX_DATA;
  logic                 TX_VALID;
  logic                 tx_ready;
  logic                 ovf_clr;
  logic                 BUSY;
  logic                 OVERFLOW;

  int checks = 0;
  int fails  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  logic [TAG_WIDTH+RES_WIDTH-1:0] mdl_held[$];
  int                             mdl_pos;
  logic                           mdl_ovf;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  tag;
    logic [7:0]  hdr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  chk;
  } vec_t;

  vec_t vecs[6];

  alu_rsp_serializer #(.RES_WIDTH(RES_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RES_DATA  (res_data),
    .RES_TAG   (res_tag),
    .RES_VALID (res_valid),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (tx_ready),
    .OVF_CLR   (ovf_clr),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Byte number pos of the frame that carries result d with tag t
  function automatic logic [7:0] frame_byte(input logic [RES_WIDTH-1:0] d,
                                            input logic [TAG_WIDTH-1:0] t,
                                            input int pos);
    logic [7:0] hdr;
    logic [7:0] x;
    hdr = 8'((int'(t) << (8 - TAG_WIDTH)) + NB);
    if (pos == 0) return hdr;
    if (pos <= NB) return 8'(d >> (8 * (pos - 1)));
    x = hdr;
    for (int i = 0; i < NB; i++) x = x ^ 8'(d >> (8 * i));
    return x;
  endfunction

  // Reference: a list of at most two held results; the head is being sent
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mdl_held.delete();
      mdl_pos = 0;
      mdl_ovf = 1'b0;
    end else begin
      if (mdl_held.size() > 0 && tx_ready) begin
        mdl_pos++;
        if (mdl_pos == FRAME_LEN) begin
          void'(mdl_held.pop_front());
          mdl_pos = 0;
        end
      end
      if (ovf_clr) mdl_ovf = 1'b0;
      if (res_valid) begin
        if (mdl_held.size() < 2) mdl_held.push_back({res_tag, res_data});
        else mdl_ovf = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [RES_WIDTH-1:0] d,
                               input logic [TAG_WIDTH-1:0] t, input logic rdy,
                               input logic clr);
    res_valid = v;
    res_data  = d;
    res_tag   = t;
    tx_ready  = rdy;
    ovf_clr   = clr;
  endtask

  // Advance one clock, recording any byte accepted on that edge
  task automatic tick();
    if (TX_VALID && tx_ready && RST) rx_q.push_back(TX_DATA);
    @(posedge CLK);
    #1;
  endtask

  task automatic pushFrame(input logic [RES_WIDTH-1:0] d, input logic [TAG_WIDTH-1:0] t);
    for (int p = 0; p < FRAME_LEN; p++) exp_q.push_back(frame_byte(d, t, p));
  endtask

  task automatic drain(input int max_cycles, output int gaps);
    int n;
    n    = 0;
    gaps = 0;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    while (BUSY && n < max_cycles) begin
      if (!TX_VALID) gaps++;
      tick();
      n++;
    end
    checkOutput("drain_idle", BUSY, 0);
  endtask

  task automatic checkStream(input string name);
    checkOutput({name, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_b%0d", name, i), rx_q[i], exp_q[i]);
  endtask

  task automatic checkModel();
    logic [TAG_WIDTH+RES_WIDTH-1:0] e;
    checkOutput("rnd_valid", TX_VALID, (mdl_held.size() > 0));
    if (mdl_held.size() > 0) begin
      e = mdl_held[0];
      checkOutput("rnd_data", TX_DATA,
                  frame_byte(e[RES_WIDTH-1:0], e[TAG_WIDTH+RES_WIDTH-1:RES_WIDTH], mdl_pos));
    end
    checkOutput("rnd_busy", BUSY, (mdl_held.size() > 0));
    checkOutput("rnd_ovf", OVERFLOW, mdl_ovf);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gaps;

    vecs[0] = '{16'h0002, 2'b10, 8'h82, 8'h02, 8'h00, 8'h80};
    vecs[1] = '{16'h1234, 2'b00, 8'h02, 8'h34, 8'h12, 8'h24};
    vecs[2] = '{16'hABCD, 2'b10, 8'h82, 8'hCD, 8'hAB, 8'hE4};
    vecs[3] = '{16'hFFFF, 2'b11, 8'hC2, 8'hFF, 8'hFF, 8'hC2};
    vecs[4] = '{16'h8001, 2'b01, 8'h42, 8'h01, 8'h80, 8'hC3};
    vecs[5] = '{16'h0000, 2'b00, 8'h02, 8'h00, 8'h00, 8'h02};

    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    checkOutput("reset_tx_data", TX_DATA, 0);
    checkOutput("reset_tx_valid", TX_VALID, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_overflow", OVERFLOW, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick();

    $display("[TB] single-frame vector table");
    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b1, vecs[v].data, vecs[v].tag, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
      checkOutput($sformatf("tbl%0d_hdr_valid", v), TX_VALID, 1);
      checkOutput($sformatf("tbl%0d_hdr", v), TX_DATA, vecs[v].hdr);
      tick();
      checkOutput($sformatf("tbl%0d_b0", v), TX_DATA, vecs[v].b0);
      tick();
      checkOutput($sformatf("tbl%0d_b1", v), TX_DATA, vecs[v].b1);
`ifdef ALU_RSP_CHECKSUM_EN
      tick();
      checkOutput($sformatf("tbl%0d_chk", v), TX_DATA, vecs[v].chk);
`endif
      tick();
      checkOutput($sformatf("tbl%0d_end_valid", v), TX_VALID, 0);
      checkOutput($sformatf("tbl%0d_end_busy", v), BUSY, 0);
    end

    $display("[TB] backpressure on header");
    rx_q.delete(); exp_q.delete();
    pushFrame(16'h0002, 2'b10);
    applyStimulus(1'b1, 16'h0002, 2'b10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", TX_VALID, 1);
      checkOutput("bp_hold_data", TX_DATA, 8'h82);
      tick();
    end
    drain(50, gaps);
    checkStream("bp");

    $display("[TB] back-to-back results");
    rx_q.delete(); exp_q.delete();
    pushFrame(16'h1234, 2'b00);
    pushFrame(16'hABCD, 2'b10);
    applyStimulus(1'b1, 16'h1234, 2'b00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'hABCD, 2'b10, 1'b1, 1'b0);
    tick();
    drain(50, gaps);
    checkOutput("b2b_gaps", gaps, 0);
    checkStream("b2b");
    checkOutput("b2b_ovf", OVERFLOW, 0);

    $display("[TB] overflow and clear");
    rx_q.delete(); exp_q.delete();
    pushFrame(16'h0001, 2'b01);
    pushFrame(16'h0002, 2'b01);
    applyStimulus(1'b1, 16'h0001, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0002, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h0003, 2'b01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("ovf_set", OVERFLOW, 1);
    drain(50, gaps);
    checkStream("ovf");
    checkOutput("ovf_sticky", OVERFLOW, 1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("ovf_clr", OVERFLOW, 0);

    $display("[TB] result coincident with frame end while pending full");
    rx_q.delete(); exp_q.delete();
    pushFrame(16'h1111, 2'b00);
    pushFrame(16'h2222, 2'b01);
    pushFrame(16'h3333, 2'b11);
    applyStimulus(1'b1, 16'h1111, 2'b00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h2222, 2'b01, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 2; i < FRAME_LEN; i++) tick();
    applyStimulus(1'b1, 16'h3333, 2'b11, 1'b1, 1'b0);
    tick();
    drain(60, gaps);
    checkStream("sim");
    checkOutput("sim_ovf", OVERFLOW, 0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(1'b1, 16'h5A5A, 2'b11, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    checkOutput("rst_pre_valid", TX_VALID, 1);
    RST = 1'b0;
    #1;
    checkOutput("rst_tx_data", TX_DATA, 0);
    checkOutput("rst_tx_valid", TX_VALID, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_overflow", OVERFLOW, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b1;
    rx_q.delete(); exp_q.delete();
    pushFrame(16'h0F0F, 2'b01);
    applyStimulus(1'b1, 16'h0F0F, 2'b01, 1'b1, 1'b0);
    tick();
    drain(50, gaps);
    checkStream("rst_after");

    $display("[TB] randomized traffic against reference");
    for (int c = 0; c < 600; c++) begin
      applyStimulus(($urandom_range(0, 2) == 0), RES_WIDTH'($urandom), TAG_WIDTH'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      tick();
      checkModel();
    end
    drain(100, gaps);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
